csc_frame_arbiter: RTL and testbench
====================================

# csc_frame_arbiter

Frame-aligned two-source arbiter that shares a single rgb2YCbCr colour-space converter between two AXI-Stream RGB video sources. It sits directly upstream of the converter. It grants the converter to one source for a whole frame, starting on start-of-frame (`ruser`) and ending after `v_active` lines (`rlast`). It drains partial-frame beats from ungranted sources and presents a registered AXI-Stream master toward the converter.

## Interface
- `data_width`, 8: bits per colour component
- `pix_per_clock`, 1: pixels per beat; beat width DW = data_width*pix_per_clock*3
- `line_cnt_width`, 12: width of line counter and `v_active`
- `clk_in`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `v_active`  in  line_cnt_width  active lines per frame; sampled at grant; 0 treated as 1
- `s0_rdata` / `s1_rdata`  in  DW  source pixel data
- `s0_rlast` / `s1_rlast`  in  1  end of line
- `s0_ruser` / `s1_ruser`  in  1  start of frame
- `s0_rvalid` / `s1_rvalid`  in  1  source valid
- `s0_rready` / `s1_rready`  out  1  source ready
- `tdata`  out  DW  to converter `rdata`
- `tlast`, `tuser`, `tvalid`  out  1  to converter
- `tready`  in  1  from converter
- `grant`  out  2  one-hot current owner; 00 = idle
- `frame_done`  out  1  one-cycle pulse on the last beat of a granted frame
- `early_sof`  out  1  one-cycle pulse when the granted source raises `ruser` mid-frame
- `drop_cnt`  out  16  saturating count of drained beats

## Operation
- States: IDLE, GNT0, GNT1.
- Output stage: one register (`tvalid`/`tdata`/`tlast`/`tuser`).
  - Signal `ok = !tvalid || tready`.
  - A source beat is accepted when `sN_rvalid && sN_rready`; it is loaded into the stage.
  - When `ok` holds and no beat is loaded, `tvalid` clears.
- IDLE:
  - Candidates are the sources with `rvalid && ruser`.
  - If both are candidates, round-robin: the source not granted last wins. After reset, s0 wins.
  - Next state is GNTn. `lines` is cleared and `v_lim = max(v_active,1)` is latched.
  - No beat is accepted in the IDLE cycle.
- GNTn:
  - `sN_rready = ok`. Each accepted beat is forwarded unchanged.
  - Accepted beat with `rlast`: `lines` increments.
  - If `lines == v_lim-1` at that beat: pulse `frame_done` and go to IDLE. `last_grant` becomes n.
  - Accepted beat with `ruser` other than the first beat: pulse `early_sof`, set `lines` to 0 (to 1 if that beat also has `rlast`), and stay in GNTn.
- Ungranted source, in any state:
  - `rvalid && !ruser`: `rready=1`, beat discarded, `drop_cnt` increments (saturates at 0xFFFF).
  - `rvalid && ruser`: `rready=0`; the beat is held until that source is granted.
- `rready` is combinational from state, `ok`, `rvalid` and `ruser`. All other outputs are registered.
- Both sources draining in the same cycle: `drop_cnt` increases by 2, with saturation.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `grant=00`, `tvalid=0`, `tdata=0`, `tlast=0`, `tuser=0`, `frame_done=0`, `early_sof=0`, `drop_cnt=0`, `last_grant` = s1 (so s0 wins first).
- Reset mid-frame: the in-flight output beat is lost and `tvalid` drops immediately. After release, the arbiter waits for the next SOF.
- Latency: an accepted beat appears on `tvalid/tdata` on the next edge.
- SOF wait: an SOF beat arriving in IDLE is accepted 1 cycle later (the grant cycle).
- Frame gap: after `frame_done` there is at least 1 IDLE cycle before the next grant.
- Backpressure: `tready=0` with `tvalid=1` holds all t* outputs stable and blocks acceptance. No beat is lost or duplicated.
- `grant` changes on the same edge as the state.
- `frame_done` and `early_sof` assert on the edge that loads the triggering beat.

## Test plan
- Single source:
  - Stimulus: `v_active=3`, 4-beat lines on s0, `tready=1`.
  - Required: 12 beats out in order, `tuser` on beat 0, `tlast` on beats 3/7/11.
  - Required: `frame_done` on beat 11, `grant` 01→00, `drop_cnt=0`.
- Simultaneous SOF:
  - Stimulus: s0 and s1 both present SOF in the same cycle after reset.
  - Required: s0 granted first and its full frame is forwarded; s1's SOF beat is held with `s1_rready=0`.
  - Required: after `frame_done` plus 1 IDLE cycle, s1 is granted. If both present SOF again, s0 wins (round-robin).
- Partial frame drain:
  - Stimulus: s1 sends 5 non-SOF beats while s0 is granted.
  - Required: `s1_rready=1` for those beats, `drop_cnt=5`, nothing from s1 reaches `tdata`.
- Backpressure:
  - Stimulus: random `tready` at 30% duty during an s0 frame.
  - Required: output sequence bit-exact with input; t* outputs stable while `tvalid && !tready`.
- Early SOF:
  - Stimulus: `v_active=4`; s0 raises `ruser` after line 2.
  - Required: `early_sof` pulse; the frame ends after 4 further lines with a single `frame_done`.
- Reset:
  - Stimulus: assert `reset_n=0` mid-frame while `tready=0`.
  - Required: `tvalid=0`, `grant=00`, `drop_cnt=0` immediately. After release, the next SOF is granted 1 cycle later.
  - Also: `v_active=0` gives a 1-line frame.

Source files
------------

// File: rtl/csc_frame_arbiter.sv
// csc_frame_arbiter
// Shares one rgb2YCbCr converter between two AXI-Stream RGB sources.
// The converter is granted to one source for a whole frame, from its
// start-of-frame beat (ruser) until v_active lines (rlast) have passed.
// Non-SOF beats from the source that does not own the converter are drained
// and counted. Beats toward the converter pass through one register stage.

module csc_frame_arbiter #(
  parameter int data_width     = 8,
  parameter int pix_per_clock  = 1,
  parameter int line_cnt_width = 12,
  localparam int dw            = data_width * pix_per_clock * 3
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic [line_cnt_width-1:0] v_active,

  input  logic [dw-1:0]             s0_rdata,
  input  logic                      s0_rlast,
  input  logic                      s0_ruser,
  input  logic                      s0_rvalid,
  output logic                      s0_rready,

  input  logic [dw-1:0]             s1_rdata,
  input  logic                      s1_rlast,
  input  logic                      s1_ruser,
  input  logic                      s1_rvalid,
  output logic                      s1_rready,

  output logic [dw-1:0]             tdata,
  output logic                      tlast,
  output logic                      tuser,
  output logic                      tvalid,
  input  logic                      tready,

  output logic [1:0]                grant,
  output logic                      frame_done,
  output logic                      early_sof,
  output logic [15:0]               drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [line_cnt_width-1:0] line_one = 1;

  state_t                    state;
  logic                      last_grant;   // 0: s0 owned last frame, 1: s1
  logic                      first_beat;   // next accepted beat is the frame's SOF beat
  logic [line_cnt_width-1:0] lines;
  logic [line_cnt_width-1:0] v_lim;

  logic                      ok;
  logic                      s0_cand;
  logic                      s1_cand;
  logic                      pick1;
  logic                      drain0;
  logic                      drain1;
  logic                      acc0;
  logic                      acc1;
  logic                      acc;
  logic [dw-1:0]             sel_data;
  logic                      sel_last;
  logic                      sel_user;
  logic                      mid_sof;
  logic [line_cnt_width-1:0] eff_lines;
  logic                      at_end;
  logic [line_cnt_width-1:0] v_lim_next;
  logic [16:0]               drop_sum;

  // Handshake, beat selection and frame-boundary decode for the current cycle
  always_comb begin
    ok      = !tvalid || tready;
    s0_cand = s0_rvalid && s0_ruser;
    s1_cand = s1_rvalid && s1_ruser;
    // s1 wins a tie only when s0 owned the previous frame
    pick1   = s1_cand && (!s0_cand || !last_grant);

    // An SOF beat from a non-owner is held so it can open its own frame later
    drain0  = (state != GNT0) && s0_rvalid && !s0_ruser;
    drain1  = (state != GNT1) && s1_rvalid && !s1_ruser;

    s0_rready = (state == GNT0) ? ok : drain0;
    s1_rready = (state == GNT1) ? ok : drain1;

    acc0 = (state == GNT0) && s0_rvalid && ok;
    acc1 = (state == GNT1) && s1_rvalid && ok;
    acc  = acc0 || acc1;

    sel_data = (state == GNT1) ? s1_rdata : s0_rdata;
    sel_last = (state == GNT1) ? s1_rlast : s0_rlast;
    sel_user = (state == GNT1) ? s1_ruser : s0_ruser;

    // An SOF inside a granted frame restarts the line count at this beat
    mid_sof   = sel_user && !first_beat;
    eff_lines = mid_sof ? '0 : lines;
    at_end    = sel_last && (eff_lines == (v_lim - line_one));

    v_lim_next = (v_active == '0) ? line_one : v_active;

    drop_sum = {1'b0, drop_cnt} + {16'b0, drain0} + {16'b0, drain1};
  end

  // Arbiter FSM with the output register stage and status pulses
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      first_beat <= 1'b0;
      lines      <= '0;
      v_lim      <= line_one;
      tvalid     <= 1'b0;
      tdata      <= '0;
      tlast      <= 1'b0;
      tuser      <= 1'b0;
      frame_done <= 1'b0;
      early_sof  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      early_sof  <= 1'b0;

      if (acc) begin
        tvalid <= 1'b1;
        tdata  <= sel_data;
        tlast  <= sel_last;
        tuser  <= sel_user;
      end else if (ok) begin
        tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s0_cand || s1_cand) begin
            state      <= pick1 ? GNT1 : GNT0;
            grant      <= pick1 ? 2'b10 : 2'b01;
            lines      <= '0;
            v_lim      <= v_lim_next;
            first_beat <= 1'b1;
          end
        end

        GNT0, GNT1: begin
          if (acc) begin
            first_beat <= 1'b0;
            if (mid_sof) begin
              early_sof <= 1'b1;
            end
            if (at_end) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              grant      <= 2'b00;
              last_grant <= (state == GNT1);
              lines      <= '0;
            end else if (sel_last) begin
              lines <= eff_lines + line_one;
            end else begin
              lines <= eff_lines;
            end
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Saturating count of beats drained from non-owning sources
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drain0 || drain1) begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_csc_frame_arbiter.sv
// Directed bench for csc_frame_arbiter: sources are driven beat by beat with
// handshakes, the output stream is captured into a queue and compared with
// hand-computed frames.

module tb_csc_frame_arbiter;

  typedef struct packed {
    logic [1:0]  g;
    logic        fd;
    logic        es;
    logic        u;
    logic        l;
    logic [23:0] d;
  } beat_t;

  logic        clk_in;
  logic        reset_n;
  logic [11:0] v_active;
  logic [23:0] s0_rdata, s1_rdata;
  logic        s0_rlast, s0_ruser, s0_rvalid, s0_rready;
  logic        s1_rlast, s1_ruser, s1_rvalid, s1_rready;
  logic [23:0] tdata;
  logic        tlast, tuser, tvalid, tready;
  logic [1:0]  grant;
  logic        frame_done, early_sof;
  logic [15:0] drop_cnt;

  int    tests_run;
  int    tests_failed;
  beat_t out_q[$];
  int    fd_cnt;
  int    es_cnt;
  int    stable_err;
  logic  prev_hold;
  logic [26:0] prev_t;
  logic  bp_done;

  csc_frame_arbiter dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .v_active   (v_active),
    .s0_rdata   (s0_rdata),
    .s0_rlast   (s0_rlast),
    .s0_ruser   (s0_ruser),
    .s0_rvalid  (s0_rvalid),
    .s0_rready  (s0_rready),
    .s1_rdata   (s1_rdata),
    .s1_rlast   (s1_rlast),
    .s1_ruser   (s1_ruser),
    .s1_rvalid  (s1_rvalid),
    .s1_rready  (s1_rready),
    .tdata      (tdata),
    .tlast      (tlast),
    .tuser      (tuser),
    .tvalid     (tvalid),
    .tready     (tready),
    .grant      (grant),
    .frame_done (frame_done),
    .early_sof  (early_sof),
    .drop_cnt   (drop_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Output monitor: captures transferred beats, counts pulses, checks hold stability
  always @(negedge clk_in) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (tvalid && tready)
        out_q.push_back('{g: grant, fd: frame_done, es: early_sof, u: tuser, l: tlast, d: tdata});
      if (frame_done) fd_cnt++;
      if (early_sof) es_cnt++;
      if (prev_hold && ({tvalid, tlast, tuser, tdata} !== prev_t)) stable_err++;
      prev_hold = tvalid && !tready;
      prev_t    = {tvalid, tlast, tuser, tdata};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    fd_cnt     = 0;
    es_cnt     = 0;
    stable_err = 0;
  endtask

  task automatic send_beat(input int src, input logic [23:0] d, input logic l,
                           input logic u, output int waited);
    int n;
    logic rdy;
    n = 0;
    if (src == 0) begin
      s0_rdata = d; s0_rlast = l; s0_ruser = u; s0_rvalid = 1'b1;
    end else begin
      s1_rdata = d; s1_rlast = l; s1_ruser = u; s1_rvalid = 1'b1;
    end
    forever begin
      @(negedge clk_in);
      rdy = (src == 0) ? s0_rready : s1_rready;
      if (rdy || n > 400) break;
      n++;
    end
    if (n > 400) begin
      tests_run++;
      tests_failed++;
      $display("FAIL handshake_timeout: source %0d beat %h got no rready, expected rready within 400 cycles", src, d);
    end
    @(posedge clk_in);
    #1;
    if (src == 0) begin
      s0_rvalid = 1'b0; s0_ruser = 1'b0; s0_rlast = 1'b0;
    end else begin
      s1_rvalid = 1'b0; s1_ruser = 1'b0; s1_rlast = 1'b0;
    end
    waited = n;
  endtask

  task automatic send_frame(input int src, input int nlines, input int bpl,
                            input logic [23:0] base, input int esof_line);
    int w;
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < bpl; b++) begin
        send_beat(src, base + 24'(l * bpl + b), (b == bpl - 1),
                  (b == 0) && (l == 0 || l == esof_line), w);
      end
    end
  endtask

  task automatic wait_out(input int n, input string name);
    int c;
    c = 0;
    while (out_q.size() < n && c < 1000) begin
      @(negedge clk_in);
      c++;
    end
    repeat (3) @(negedge clk_in);
    tests_run++;
    if (out_q.size() != n) begin
      tests_failed++;
      $display("FAIL %s_beat_count: got %0d beats, expected %0d", name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    v_active  = 12'd1;
    s0_rdata  = '0; s0_rlast = 0; s0_ruser = 0; s0_rvalid = 0;
    s1_rdata  = '0; s1_rlast = 0; s1_ruser = 0; s1_rvalid = 0;
    tready    = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b, expected 00", grant); end
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b, expected 0", tvalid); end
    tests_run++; if (tdata !== 24'h0) begin tests_failed++; $display("FAIL reset_tdata: got %h, expected 000000", tdata); end
    tests_run++; if ({tlast, tuser} !== 2'b00) begin tests_failed++; $display("FAIL reset_tlast_tuser: got %b, expected 00", {tlast, tuser}); end
    tests_run++; if ({frame_done, early_sof} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: got %b, expected 00", {frame_done, early_sof}); end
    tests_run++; if (drop_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %h, expected 0000", drop_cnt); end
    tests_run++; if ({s0_rready, s1_rready} !== 2'b00) begin tests_failed++; $display("FAIL reset_rready: got %b, expected 00", {s0_rready, s1_rready}); end
    @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  task automatic test_simul_sof();
    logic [23:0] bases [4];
    logic [23:0] exp_d;
    logic [1:0]  exp_g;
    bases[0] = 24'h010000; bases[1] = 24'h110000;
    bases[2] = 24'h020000; bases[3] = 24'h120000;
    v_active = 12'd1;
    clear_mon();
    sync();
    fork
      begin
        send_frame(0, 1, 2, 24'h010000, -1);
        send_frame(0, 1, 2, 24'h020000, -1);
      end
      begin
        send_frame(1, 1, 2, 24'h110000, -1);
        send_frame(1, 1, 2, 24'h120000, -1);
      end
      begin
        @(negedge clk_in);
        tests_run++; if ({s0_rready, s1_rready} !== 2'b00) begin tests_failed++; $display("FAIL simul_idle_rready: got %b, expected 00", {s0_rready, s1_rready}); end
        @(negedge clk_in);
        tests_run++; if ({grant, s0_rready, s1_rready} !== 4'b0110) begin tests_failed++; $display("FAIL simul_first_grant: got grant=%b rready=%b%b, expected grant=01 rready=10", grant, s0_rready, s1_rready); end
      end
    join
    wait_out(8, "simul");
    for (int i = 0; i < 8; i++) begin
      exp_d = bases[i / 2] + 24'(i % 2);
      exp_g = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++;
      if (out_q[i].d !== exp_d || out_q[i].u !== (i % 2 == 0) || out_q[i].l !== (i % 2 == 1)) begin
        tests_failed++;
        $display("FAIL simul_beat[%0d]: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                 i, out_q[i].d, out_q[i].u, out_q[i].l, exp_d, (i % 2 == 0), (i % 2 == 1));
      end
      if (i % 2 == 0) begin
        tests_run++;
        if (out_q[i].g !== exp_g) begin tests_failed++; $display("FAIL simul_grant[%0d]: got %b, expected %b", i, out_q[i].g, exp_g); end
      end
    end
    tests_run++; if (fd_cnt != 4) begin tests_failed++; $display("FAIL simul_frame_done_count: got %0d, expected 4", fd_cnt); end
  endtask

  task automatic test_single();
    logic [23:0] exp_d;
    v_active = 12'd3;
    tready   = 1'b1;
    clear_mon();
    sync();
    send_frame(0, 3, 4, 24'h100000, -1);
    wait_out(12, "single");
    for (int i = 0; i < 12; i++) begin
      exp_d = 24'h100000 + 24'(i);
      tests_run++;
      if (out_q[i].d !== exp_d || out_q[i].u !== (i == 0) || out_q[i].l !== (i % 4 == 3)) begin
        tests_failed++;
        $display("FAIL single_beat[%0d]: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                 i, out_q[i].d, out_q[i].u, out_q[i].l, exp_d, (i == 0), (i % 4 == 3));
      end
    end
    tests_run++; if (out_q[0].g !== 2'b01) begin tests_failed++; $display("FAIL single_grant_open: got %b, expected 01", out_q[0].g); end
    tests_run++; if (out_q[11].g !== 2'b00 || out_q[11].fd !== 1'b1) begin tests_failed++; $display("FAIL single_frame_end: got grant=%b fd=%b, expected grant=00 fd=1", out_q[11].g, out_q[11].fd); end
    tests_run++; if (fd_cnt != 1) begin tests_failed++; $display("FAIL single_frame_done_count: got %0d, expected 1", fd_cnt); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL single_drop_cnt: got %0d, expected 0", drop_cnt); end
  endtask

  task automatic test_drain();
    logic [15:0] d0;
    logic [23:0] exp_d;
    int          wsum;
    int          w;
    v_active = 12'd2;
    wsum     = 0;
    clear_mon();
    sync();
    d0 = drop_cnt;
    fork
      send_frame(0, 2, 4, 24'h200000, -1);
      begin
        for (int i = 0; i < 5; i++) begin
          send_beat(1, 24'hBAD000 + 24'(i), 1'b0, 1'b0, w);
          wsum += w;
        end
      end
    join
    wait_out(8, "drain");
    for (int i = 0; i < 8; i++) begin
      exp_d = 24'h200000 + 24'(i);
      tests_run++;
      if (out_q[i].d !== exp_d) begin tests_failed++; $display("FAIL drain_beat[%0d]: got %h, expected %h", i, out_q[i].d, exp_d); end
    end
    tests_run++; if (wsum != 0) begin tests_failed++; $display("FAIL drain_rready: got %0d stall cycles, expected 0", wsum); end
    tests_run++; if (drop_cnt - d0 !== 16'd5) begin tests_failed++; $display("FAIL drain_drop_cnt: got +%0d, expected +5", drop_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_d;
    v_active = 12'd2;
    bp_done  = 1'b0;
    clear_mon();
    sync();
    fork
      begin
        send_frame(0, 2, 4, 24'h300000, -1);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk_in);
          #1;
          tready = ($urandom_range(0, 99) < 30);
        end
      end
    join
    tready = 1'b1;
    wait_out(8, "bp");
    for (int i = 0; i < 8; i++) begin
      exp_d = 24'h300000 + 24'(i);
      tests_run++;
      if (out_q[i].d !== exp_d || out_q[i].u !== (i == 0) || out_q[i].l !== (i % 4 == 3)) begin
        tests_failed++;
        $display("FAIL bp_beat[%0d]: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                 i, out_q[i].d, out_q[i].u, out_q[i].l, exp_d, (i == 0), (i % 4 == 3));
      end
    end
    tests_run++; if (stable_err != 0) begin tests_failed++; $display("FAIL bp_hold_stable: got %0d changes while stalled, expected 0", stable_err); end
    tests_run++; if (fd_cnt != 1) begin tests_failed++; $display("FAIL bp_frame_done_count: got %0d, expected 1", fd_cnt); end
  endtask

  task automatic test_early_sof();
    logic [23:0] exp_d;
    v_active = 12'd4;
    tready   = 1'b1;
    clear_mon();
    sync();
    send_frame(0, 6, 2, 24'h400000, 2);
    wait_out(12, "esof");
    for (int i = 0; i < 12; i++) begin
      exp_d = 24'h400000 + 24'(i);
      tests_run++;
      if (out_q[i].d !== exp_d || out_q[i].u !== (i == 0 || i == 4)) begin
        tests_failed++;
        $display("FAIL esof_beat[%0d]: got d=%h u=%b, expected d=%h u=%b", i, out_q[i].d, out_q[i].u, exp_d, (i == 0 || i == 4));
      end
    end
    tests_run++; if (out_q[4].es !== 1'b1 || es_cnt != 1) begin tests_failed++; $display("FAIL esof_pulse: got beat4 es=%b count=%0d, expected es=1 count=1", out_q[4].es, es_cnt); end
    tests_run++; if (out_q[11].fd !== 1'b1 || fd_cnt != 1) begin tests_failed++; $display("FAIL esof_frame_done: got beat11 fd=%b count=%0d, expected fd=1 count=1", out_q[11].fd, fd_cnt); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL esof_grant_end: got %b, expected 00", grant); end
  endtask

  task automatic test_reset_mid();
    sync();
    v_active  = 12'd2;
    tready    = 1'b0;
    s0_rdata  = 24'h5A5A5A; s0_rlast = 1'b0; s0_ruser = 1'b1; s0_rvalid = 1'b1;
    s1_rdata  = 24'h777777; s1_rlast = 1'b0; s1_ruser = 1'b0; s1_rvalid = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++; if ({tvalid, grant} !== 3'b101 || tdata !== 24'h5A5A5A) begin tests_failed++; $display("FAIL rstmid_stalled: got tvalid=%b grant=%b tdata=%h, expected 1 01 5a5a5a", tvalid, grant, tdata); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tvalid: got %b, expected 0", tvalid); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rstmid_grant: got %b, expected 00", grant); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL rstmid_drop_cnt: got %0d, expected 0", drop_cnt); end
    s0_rvalid = 1'b0; s0_ruser = 1'b0;
    s1_rvalid = 1'b0;
    tready    = 1'b1;
    @(negedge clk_in);
    reset_n = 1'b1;
    clear_mon();
    v_active = 12'd0;
    sync();
    fork
      send_frame(0, 1, 2, 24'h600000, -1);
      begin
        @(negedge clk_in);
        tests_run++; if (s0_rready !== 1'b0) begin tests_failed++; $display("FAIL sof_wait_idle: got rready=%b, expected 0", s0_rready); end
        @(negedge clk_in);
        tests_run++; if ({s0_rready, grant} !== 3'b101) begin tests_failed++; $display("FAIL sof_wait_grant: got rready=%b grant=%b, expected 1 01", s0_rready, grant); end
      end
    join
    wait_out(2, "vzero");
    tests_run++; if (out_q[0].d !== 24'h600000 || out_q[1].d !== 24'h600001) begin tests_failed++; $display("FAIL vzero_data: got %h %h, expected 600000 600001", out_q[0].d, out_q[1].d); end
    tests_run++; if (out_q[1].fd !== 1'b1 || fd_cnt != 1) begin tests_failed++; $display("FAIL vzero_frame_done: got fd=%b count=%0d, expected fd=1 count=1", out_q[1].fd, fd_cnt); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL vzero_grant_end: got %b, expected 00", grant); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    prev_hold    = 1'b0;
    prev_t       = '0;
    bp_done      = 1'b0;
    test_reset();
    test_simul_sof();
    test_single();
    test_drain();
    test_backpressure();
    test_early_sof();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
